dadda_mul_arbiter: RTL and testbench

- Shares one 16x16 signed Dadda-tree multiplier (`dadda1`, purely combinational) among NREQ requesters.
- Round-robin arbitration picks one requester per cycle.
- Operand and product registers are placed around the multiplier, giving a 2-stage pipeline with a valid/ready output and backpressure.
- The block sits between DSP clients and the multiplier and tags each result with the originating requester ID.

---
 rtl/dadda_mul_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// Shared signed 16x16 Dadda-tree multiplier with a round-robin front end.
// Requests are granted one per cycle into an operand register (S1); the
// product is registered in the output stage (S2) with valid/ready handshake.

module dadda1 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] prod
);
    localparam int N      = 16;
    localparam int W      = 32;
    localparam int MAXH   = 17;
    localparam int NSTAGE = 6;
    localparam int MAXOPS = 8;

    logic [MAXH-1:0] mat  [W];
    logic [MAXH-1:0] nxt  [W];
    int              hgt  [W];
    int              nhgt [W];
    logic [W-1:0]    row0;
    logic [W-1:0]    row1;
    int              used;
    int              target;
    logic            x;
    logic            y;
    logic            z;

    // Dadda height sequence, tallest first; the matrix starts at height 16.
    function automatic int stage_target(input int s);
        case (s)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // Baugh-Wooley partial products, Dadda column reduction, final two-row add.
    always_comb begin
        for (int c = 0; c < W; c++) begin
            mat[c]  = '0;
            nxt[c]  = '0;
            hgt[c]  = 0;
            nhgt[c] = 0;
        end
        used   = 0;
        target = 0;
        x      = 1'b0;
        y      = 1'b0;
        z      = 1'b0;
        row0   = '0;
        row1   = '0;

        // Cross terms touching exactly one sign bit are inverted; the two
        // constant ones at columns 16 and 31 complete the signed correction,
        // so zero operands collapse to exactly zero modulo 2**32.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ((i == N-1) != (j == N-1))
                    mat[5'(i+j)][5'(hgt[5'(i+j)])] = ~(a[j] & b[i]);
                else
                    mat[5'(i+j)][5'(hgt[5'(i+j)])] = a[j] & b[i];
                hgt[5'(i+j)] = hgt[5'(i+j)] + 1;
            end
        end
        mat[5'(N)][5'(hgt[5'(N)])] = 1'b1;
        hgt[5'(N)] = hgt[5'(N)] + 1;
        mat[5'(W-1)][5'(hgt[5'(W-1)])] = 1'b1;
        hgt[5'(W-1)] = hgt[5'(W-1)] + 1;

        // Each stage squeezes every column (own bits plus incoming carries)
        // down to the stage target using the minimum number of adders.
        for (int s = 0; s < NSTAGE; s++) begin
            target = stage_target(s);
            for (int c = 0; c < W; c++) begin
                nxt[c]  = '0;
                nhgt[c] = 0;
            end
            for (int c = 0; c < W; c++) begin
                used = 0;
                for (int k = 0; k < MAXOPS; k++) begin
                    if (hgt[c] - used + nhgt[c] == target + 1) begin
                        x = mat[c][5'(used)];
                        y = mat[c][5'(used + 1)];
                        nxt[c][5'(nhgt[c])] = x ^ y;
                        nhgt[c] = nhgt[c] + 1;
                        if (c < W-1) begin
                            nxt[5'(c+1)][5'(nhgt[5'(c+1)])] = x & y;
                            nhgt[5'(c+1)] = nhgt[5'(c+1)] + 1;
                        end
                        used = used + 2;
                    end else if (hgt[c] - used + nhgt[c] > target + 1) begin
                        x = mat[c][5'(used)];
                        y = mat[c][5'(used + 1)];
                        z = mat[c][5'(used + 2)];
                        nxt[c][5'(nhgt[c])] = x ^ y ^ z;
                        nhgt[c] = nhgt[c] + 1;
                        if (c < W-1) begin
                            nxt[5'(c+1)][5'(nhgt[5'(c+1)])] = (x & y) | (x & z) | (y & z);
                            nhgt[5'(c+1)] = nhgt[5'(c+1)] + 1;
                        end
                        used = used + 3;
                    end
                end
                for (int j = 0; j < MAXH; j++) begin
                    if (j >= used && j < hgt[c]) begin
                        nxt[c][5'(nhgt[c])] = mat[c][j];
                        nhgt[c] = nhgt[c] + 1;
                    end
                end
            end
            for (int c = 0; c < W; c++) begin
                mat[c] = nxt[c];
                hgt[c] = nhgt[c];
            end
        end

        for (int c = 0; c < W; c++) begin
            row0[c] = (hgt[c] > 0) ? mat[c][0] : 1'b0;
            row1[c] = (hgt[c] > 1) ? mat[c][1] : 1'b0;
        end
        prod = row0 + row1;
    end
endmodule

module dadda_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_prod,
    output logic [ID_W-1:0]      out_id,
    output logic [15:0]          done_cnt,
    output logic                 busy
);
    // NREQ must not exceed 2**ID_W so every requester has a distinct ID.

    logic            s1_valid;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic [ID_W-1:0] s1_id;
    logic [ID_W-1:0] ptr;
    logic [31:0]     mul_prod;
    logic            adv;
    logic            accept;
    logic            grant_any;
    logic            found_hi;
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic [ID_W-1:0] winner;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;

    // Multiplier sees registered operands only, so req_* never reaches out_*.
    dadda1 u_mul (
        .a    (s1_a),
        .b    (s1_b),
        .prod (mul_prod)
    );

    assign adv    = !out_valid || out_ready;
    assign accept = grant_any && adv && !rst;
    assign busy   = s1_valid || out_valid;

    // Round-robin search: first valid at or above ptr, else first valid overall.
    always_comb begin
        found_hi  = 1'b0;
        grant_any = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_hi && req_valid[i] && (ID_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                win_hi   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                win_lo    = ID_W'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    // One-hot ready to the winner plus the winner's operand selection.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_a        = req_a[16*i +: 16];
                sel_b        = req_b[16*i +: 16];
            end
        end
    end

    // Two-stage pipeline shift; both stages freeze together under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_id    <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_prod  <= mul_prod;
            out_id    <= s1_id;
            s1_valid  <= grant_any;
            s1_a      <= sel_a;
            s1_b      <= sel_b;
            s1_id     <= winner;
        end
    end

    // Fairness pointer moves past the winner on accept; delivery counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            done_cnt <= '0;
        end else begin
            if (accept) begin
                if (winner == ID_W'(NREQ-1))
                    ptr <= '0;
                else
                    ptr <= winner + 1'b1;
            end
            if (out_valid && out_ready)
                done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed bench for dadda_mul_arbiter: arbitration order, pipeline timing,
// signed corner products, backpressure, mid-flight reset and counter wrap.

module tb_dadda_mul_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_prod;
    logic [ID_W-1:0]   out_id;
    logic [15:0]       done_cnt;
    logic              busy;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [15:0] stream_a [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [15:0] stream_b [4] = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB};
    logic [31:0] stream_p [4] = '{32'hFFFFFF38, 32'hFFFFFDA8, 32'hFFFFFB50, 32'hFFFFF830};
    int          rr_order [5] = '{0, 1, 2, 3, 0};

    logic [15:0] corner_a [6] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'd12345, 16'h8000};
    logic [15:0] corner_b [6] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [31:0] corner_p [6] = '{32'h40000000, 32'hC0008000, 32'h00000000,
                                  32'h00000001, 32'hFFFFCFC7, 32'h00000000};

    dadda_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_id    (out_id),
        .done_cnt  (done_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        guard     = 0;

        $display("[TB] reset state");
        repeat (2) tick();
        req_valid = 4'hF;
        #1;
        checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_done_cnt", 32'(done_cnt), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        req_valid = '0;
        rst       = 1'b0;
        #1;

        $display("[TB] single request from requester 1");
        applyStimulus(1, 16'hFFFD, 16'd5);
        req_valid = 4'b0010;
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_not_yet", 32'(out_valid), 32'h0);
        tick();
        checkOutput("single_valid", 32'(out_valid), 32'h1);
        checkOutput("single_prod", out_prod, 32'hFFFFFFF1);
        checkOutput("single_id", 32'(out_id), 32'h1);
        tick();
        checkOutput("single_done_cnt", 32'(done_cnt), 32'h1);
        checkOutput("single_drained", 32'(out_valid), 32'h0);

        $display("[TB] round-robin with all requesters active");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, stream_a[i], stream_b[i]);
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) begin
                req_valid = '0;
                #1;
            end
            if (k < 5)
                checkOutput($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1) << rr_order[k]);
            if (k >= 2) begin
                checkOutput($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'h1);
                checkOutput($sformatf("rr_id_%0d", k), 32'(out_id), 32'(rr_order[k-2]));
                checkOutput($sformatf("rr_prod_%0d", k), out_prod, stream_p[rr_order[k-2]]);
            end
            tick();
        end
        checkOutput("rr_drained", 32'(out_valid), 32'h0);
        checkOutput("rr_done_cnt", 32'(done_cnt), 32'd5);

        $display("[TB] corner operands through requester 3");
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                applyStimulus(3, corner_a[k], corner_b[k]);
                req_valid = 4'b1000;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 6)
                checkOutput($sformatf("corner_ready_%0d", k), 32'(req_ready), 32'h8);
            if (k >= 2) begin
                checkOutput($sformatf("corner_id_%0d", k - 2), 32'(out_id), 32'h3);
                checkOutput($sformatf("corner_prod_%0d", k - 2), out_prod, corner_p[k-2]);
            end
            tick();
        end
        checkOutput("corner_drained", 32'(out_valid), 32'h0);
        checkOutput("corner_done_cnt", 32'(done_cnt), 32'd11);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(0, 16'd7, 16'd6);
        applyStimulus(1, 16'hFFF7, 16'd9);
        applyStimulus(2, 16'd1000, 16'd1000);
        req_valid = 4'b0111;
        #1;
        checkOutput("bp_ready_0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0110;
        #1;
        checkOutput("bp_ready_1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_stall_valid_%0d", k), 32'(out_valid), 32'h1);
            checkOutput($sformatf("bp_stall_prod_%0d", k), out_prod, 32'h0000002A);
            checkOutput($sformatf("bp_stall_id_%0d", k), 32'(out_id), 32'h0);
            checkOutput($sformatf("bp_stall_ready_%0d", k), 32'(req_ready), 32'h0);
            tick();
        end
        checkOutput("bp_stall_done_cnt", 32'(done_cnt), 32'd11);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        checkOutput("bp_prod_1", out_prod, 32'hFFFFFFAF);
        checkOutput("bp_id_1", 32'(out_id), 32'h1);
        checkOutput("bp_done_cnt_1", 32'(done_cnt), 32'd12);
        tick();
        checkOutput("bp_prod_2", out_prod, 32'h000F4240);
        checkOutput("bp_id_2", 32'(out_id), 32'h2);
        tick();
        checkOutput("bp_drained", 32'(out_valid), 32'h0);
        checkOutput("bp_done_cnt", 32'(done_cnt), 32'd14);
        checkOutput("bp_busy", 32'(busy), 32'h0);

        $display("[TB] reset with both stages full");
        out_ready = 1'b0;
        applyStimulus(0, 16'd11, 16'd11);
        applyStimulus(1, 16'd2, 16'd3);
        req_valid = 4'b0011;
        #1;
        checkOutput("mid_ready_0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #1;
        checkOutput("mid_full_valid", 32'(out_valid), 32'h1);
        checkOutput("mid_full_busy", 32'(busy), 32'h1);
        rst       = 1'b1;
        req_valid = 4'b0101;
        #1;
        checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy), 32'h0);
        checkOutput("mid_rst_done_cnt", 32'(done_cnt), 32'h0);
        out_ready = 1'b1;
        applyStimulus(0, 16'hFFFB, 16'hFFFA);
        applyStimulus(2, 16'd3, 16'hFFF9);
        req_valid = 4'b0101;
        #1;
        checkOutput("post_rst_ready_0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0100;
        #1;
        checkOutput("post_rst_ready_2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        checkOutput("post_rst_id_0", 32'(out_id), 32'h0);
        checkOutput("post_rst_prod_0", out_prod, 32'h0000001E);
        tick();
        checkOutput("post_rst_id_2", 32'(out_id), 32'h2);
        checkOutput("post_rst_prod_2", out_prod, 32'hFFFFFFEB);
        tick();
        checkOutput("post_rst_drained", 32'(out_valid), 32'h0);
        checkOutput("post_rst_done_cnt", 32'(done_cnt), 32'd2);

        $display("[TB] delivery counter wrap");
        applyStimulus(0, 16'd1, 16'd1);
        req_valid = 4'b0001;
        while (done_cnt != 16'hFFFE && guard < 70000) begin
            tick();
            guard++;
        end
        req_valid = '0;
        checkOutput("wrap_reach", 32'(done_cnt), 32'h0000FFFE);
        tick();
        checkOutput("wrap_ffff", 32'(done_cnt), 32'h0000FFFF);
        checkOutput("wrap_last_valid", 32'(out_valid), 32'h1);
        tick();
        checkOutput("wrap_zero", 32'(done_cnt), 32'h00000000);
        checkOutput("wrap_drained", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
